sva_result_collector: RTL and testbench
=======================================

Name: sva_result_collector

Overview:
- Downstream consumer of the SVA-FSM checker's per-evaluation result pulses: succ, fail and lazy_succ.
- Counts each result kind, timestamps events against user-clock ticks and captures the first failure.
- Buffers events in a small FIFO for readout by the testbench or host.
- Produces a final pass/fail verdict per run through a run-control FSM.

Parameters:
- CNT_WIDTH, 16, width of each saturating result counter.
- TS_WIDTH, 16, width of the tick counter and of event timestamps.
- FIFO_DEPTH, 8, number of event FIFO entries; power of two, at least 2.
- MIN_SUCC, 1, minimum succ_cnt required for a PASS verdict.
- STOP_ON_FAIL, 1, when 1, the first fail moves the FSM to FAILED and freezes counting.

Ports:
- sys_clk  input  1  single clock; all logic is on its rising edge.
- sys_rst_n  input  1  asynchronous, active-low reset.
- start  input  1  pulse: begin a run (honoured in IDLE only).
- stop  input  1  pulse: end a run (honoured in RUN or FAILED).
- clear  input  1  pulse: return from DONE to IDLE.
- gclk_tick  input  1  one-cycle flag at each user-clock posedge.
- succ  input  1  checker success; each cycle high counts as one event.
- fail  input  1  checker failure; each cycle high counts as one event.
- lazy_succ  input  1  checker lazy success; each cycle high counts as one event.
- succ_cnt  output  CNT_WIDTH  saturating count of successes.
- fail_cnt  output  CNT_WIDTH  saturating count of failures.
- lazy_cnt  output  CNT_WIDTH  saturating count of lazy successes.
- first_fail_vld  output  1  sticky: a fail has been captured this run.
- first_fail_ts  output  TS_WIDTH  tick_cnt value at the first fail.
- evt_valid  output  1  FIFO non-empty.
- evt_ready  input  1  consumer accepts the head entry.
- evt_kind  output  2  head entry kind: 1=succ, 2=fail, 3=lazy.
- evt_ts  output  TS_WIDTH  head entry timestamp.
- evt_ovf  output  1  sticky: at least one event was dropped because the FIFO was full.
- state  output  2  current FSM state: 0=IDLE, 1=RUN, 2=FAILED, 3=DONE.
- verdict  output  2  0=none, 1=PASS, 2=FAIL; valid in DONE only.

Behaviour:
- Reset (sys_rst_n low, asynchronous):
  - state=IDLE.
  - All counters, first_fail_ts and tick_cnt = 0.
  - first_fail_vld=0, evt_ovf=0, verdict=0.
  - FIFO empty, so evt_valid=0; evt_kind=0 and evt_ts=0 while empty.
- FSM:
  - IDLE: on start, go to RUN and clear the counters, tick_cnt, first-fail capture, evt_ovf and the FIFO in that same edge.
  - RUN: on stop, go to DONE. On fail with STOP_ON_FAIL=1, go to FAILED. stop has priority over fail in the same cycle, but that fail is still counted and captured.
  - FAILED: input pulses are ignored except stop, which goes to DONE.
  - DONE: on clear, go to IDLE. verdict updates on the edge entering DONE:
    - PASS if fail_cnt==0 and succ_cnt>=MIN_SUCC;
    - FAIL otherwise.
  - start outside IDLE and clear outside DONE are ignored.
- Counting (RUN only):
  - Each result input high in a cycle adds 1 to its own counter; simultaneous inputs each count.
  - Counters saturate at all-ones; no wrap.
  - Counter results are visible on the cycle after the input.
- Tick counter: in RUN, gclk_tick increments tick_cnt, saturating at all-ones.
- Timestamps:
  - Event timestamp = tick_cnt value before that cycle's increment.
  - first_fail_ts is loaded on the first fail of the run; later fails do not change it.
- FIFO push:
  - At most one push per cycle, in RUN, or on the RUN->FAILED edge.
  - Priority when several inputs are high: fail > succ > lazy_succ. Lower-priority events in the same cycle are counted but not queued, and do not set evt_ovf.
- FIFO full:
  - A push is dropped and evt_ovf is set.
  - A simultaneous pop (evt_valid & evt_ready) frees a slot in the same cycle, so the push succeeds.
- FIFO read:
  - Show-ahead: the head is presented combinationally from storage.
  - Pop on evt_valid & evt_ready; no pop while empty.
  - Latency from push to evt_valid = 1 cycle.
  - Read pointers run in every state, so the FIFO can be drained in DONE.
- Mid-operation reset: returns to IDLE; all data is lost.

Test Plan:
- Basic pass: start; 3 gclk_tick; succ at tick 2; stop -> succ_cnt=1, FIFO holds {1,2}, state=DONE, verdict=1.
- First fail with STOP_ON_FAIL=1: start; ticks 0..4; fail at ts=3 -> state=FAILED, first_fail_ts=3, fail_cnt=1. A later succ is not counted. stop -> verdict=2.
- Simultaneous inputs: succ, fail and lazy_succ all high in one RUN cycle (STOP_ON_FAIL=0) -> each counter=1, exactly one FIFO entry with kind=2, evt_ovf=0.
- Overflow: evt_ready=0; 9 succ pulses with FIFO_DEPTH=8 -> 8 entries, evt_ovf=1, succ_cnt=9. Then push and pop together when full -> no drop.
- Saturation: CNT_WIDTH=4; 20 succ pulses -> succ_cnt=15.
- Control: reset asserted mid-RUN -> all outputs return to their reset values at once. clear in DONE -> IDLE. start in RUN -> ignored.

Source files
------------

// File: rtl/sva_result_collector_if.sv
// Bundled control, result and event-readout signals of the SVA result collector.
interface sva_result_collector_if #(
  parameter int CNT_WIDTH = 16,
  parameter int TS_WIDTH  = 16
);
  logic                 start, stop, clear, gclk_tick;
  logic                 succ, fail, lazy_succ, evt_ready;
  logic [CNT_WIDTH-1:0] succ_cnt, fail_cnt, lazy_cnt;
  logic                 first_fail_vld;
  logic [TS_WIDTH-1:0]  first_fail_ts;
  logic                 evt_valid, evt_ovf;
  logic [1:0]           evt_kind;
  logic [TS_WIDTH-1:0]  evt_ts;
  logic [1:0]           state, verdict;

  modport slave (
    input  start, stop, clear, gclk_tick, succ, fail, lazy_succ, evt_ready,
    output succ_cnt, fail_cnt, lazy_cnt, first_fail_vld, first_fail_ts,
           evt_valid, evt_kind, evt_ts, evt_ovf, state, verdict
  );
  modport master (
    output start, stop, clear, gclk_tick, succ, fail, lazy_succ, evt_ready,
    input  succ_cnt, fail_cnt, lazy_cnt, first_fail_vld, first_fail_ts,
           evt_valid, evt_kind, evt_ts, evt_ovf, state, verdict
  );
endinterface

// File: rtl/sva_result_collector.sv
// Counts SVA checker result pulses, timestamps them, queues events in a FIFO
// and produces a per-run pass/fail verdict.
module sva_result_collector #(
  parameter int CNT_WIDTH    = 16,
  parameter int TS_WIDTH     = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int MIN_SUCC     = 1,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  sva_result_collector_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_FAILED = 2'd2, S_DONE = 2'd3;
  localparam logic [1:0] V_PASS = 2'd1, V_FAIL = 2'd2;

  logic [1:0]           state_q, state_d, verdict_q, verdict_d;
  logic [CNT_WIDTH-1:0] succ_q, succ_d, fail_q, fail_d, lazy_q, lazy_d;
  logic [TS_WIDTH-1:0]  tick_q, tick_d, ffts_q, ffts_d;
  logic                 ffv_q, ffv_d, ovf_q, ovf_d;
  logic [AW:0]          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0]           kind_mem [FIFO_DEPTH];
  logic [TS_WIDTH-1:0]  ts_mem   [FIFO_DEPTH];

  logic       run, flush, empty, full, pop, push, ends;
  logic [1:0] push_kind;

  assign run   = (state_q == S_RUN);
  assign flush = (state_q == S_IDLE) && bus.start;
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = !empty && bus.evt_ready;
  assign push_kind = bus.fail ? 2'd2 : bus.succ ? 2'd1 : bus.lazy_succ ? 2'd3 : 2'd0;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push  = run && (push_kind != 2'd0) && (!full || pop);
  assign ends  = bus.stop && (run || state_q == S_FAILED);

  always_comb begin
    state_d   = state_q;
    verdict_d = verdict_q;
    succ_d    = succ_q;
    fail_d    = fail_q;
    lazy_d    = lazy_q;
    tick_d    = tick_q;
    ffv_d     = ffv_q;
    ffts_d    = ffts_q;
    ovf_d     = ovf_q;
    if (flush) begin
      state_d = S_RUN;
      succ_d  = '0;
      fail_d  = '0;
      lazy_d  = '0;
      tick_d  = '0;
      ffv_d   = 1'b0;
      ffts_d  = '0;
      ovf_d   = 1'b0;
    end else if (run) begin
      if (bus.succ && !(&succ_q))      succ_d = succ_q + 1'b1;
      if (bus.fail && !(&fail_q))      fail_d = fail_q + 1'b1;
      if (bus.lazy_succ && !(&lazy_q)) lazy_d = lazy_q + 1'b1;
      if (bus.gclk_tick && !(&tick_q)) tick_d = tick_q + 1'b1;
      if (bus.fail && !ffv_q) begin
        ffv_d  = 1'b1;
        ffts_d = tick_q;
      end
      if ((push_kind != 2'd0) && !push) ovf_d = 1'b1;
      if (!bus.stop && bus.fail && STOP_ON_FAIL) state_d = S_FAILED;
    end else if (state_q == S_DONE && bus.clear) begin
      state_d = S_IDLE;
    end
    // Verdict sees this cycle's counts, so a fail coincident with stop still fails.
    if (ends) begin
      state_d   = S_DONE;
      verdict_d = (fail_d == '0 && 32'(succ_d) >= MIN_SUCC) ? V_PASS : V_FAIL;
    end
  end

  assign rptr_d = flush ? '0 : rptr_q + (AW+1)'(pop);
  assign wptr_d = flush ? '0 : wptr_q + (AW+1)'(push);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      verdict_q <= 2'd0;
      succ_q    <= '0;
      fail_q    <= '0;
      lazy_q    <= '0;
      tick_q    <= '0;
      ffv_q     <= 1'b0;
      ffts_q    <= '0;
      ovf_q     <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      state_q   <= state_d;
      verdict_q <= verdict_d;
      succ_q    <= succ_d;
      fail_q    <= fail_d;
      lazy_q    <= lazy_d;
      tick_q    <= tick_d;
      ffv_q     <= ffv_d;
      ffts_q    <= ffts_d;
      ovf_q     <= ovf_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) begin
      kind_mem[wptr_q[AW-1:0]] <= push_kind;
      ts_mem[wptr_q[AW-1:0]]   <= tick_q;
    end
  end

  assign bus.succ_cnt       = succ_q;
  assign bus.fail_cnt       = fail_q;
  assign bus.lazy_cnt       = lazy_q;
  assign bus.first_fail_vld = ffv_q;
  assign bus.first_fail_ts  = ffts_q;
  assign bus.evt_valid      = !empty;
  assign bus.evt_kind       = empty ? 2'd0 : kind_mem[rptr_q[AW-1:0]];
  assign bus.evt_ts         = empty ? '0 : ts_mem[rptr_q[AW-1:0]];
  assign bus.evt_ovf        = ovf_q;
  assign bus.state          = state_q;
  assign bus.verdict        = (state_q == S_DONE) ? verdict_q : 2'd0;
endmodule

// File: tb/tb_sva_result_collector.sv
// Drives two collector configurations with shared stimulus and checks every
// output each cycle against a queue-based reference model.
module tb_sva_result_collector;
  logic sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic start = 0, stop = 0, clear = 0, tick = 0, succ = 0, fail = 0, lazy = 0, rdy = 0;
  int n_chk = 0, n_err = 0;

  always #5 sys_clk = ~sys_clk;

  sva_result_collector_if #(.CNT_WIDTH(16), .TS_WIDTH(16)) if0 ();
  sva_result_collector_if #(.CNT_WIDTH(4),  .TS_WIDTH(16)) if1 ();

  assign {if0.start, if0.stop, if0.clear, if0.gclk_tick} = {start, stop, clear, tick};
  assign {if0.succ, if0.fail, if0.lazy_succ, if0.evt_ready} = {succ, fail, lazy, rdy};
  assign {if1.start, if1.stop, if1.clear, if1.gclk_tick} = {start, stop, clear, tick};
  assign {if1.succ, if1.fail, if1.lazy_succ, if1.evt_ready} = {succ, fail, lazy, rdy};

  sva_result_collector #(.CNT_WIDTH(16), .TS_WIDTH(16), .FIFO_DEPTH(8), .MIN_SUCC(1),
    .STOP_ON_FAIL(1'b1)) u0 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if0));
  sva_result_collector #(.CNT_WIDTH(4), .TS_WIDTH(16), .FIFO_DEPTH(8), .MIN_SUCC(1),
    .STOP_ON_FAIL(1'b0)) u1 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if1));

  // Reference model: 0=IDLE 1=RUN 2=FAILED 3=DONE; FIFO entries are kind<<16 | ts.
  int m_st[2], m_sc[2], m_fc[2], m_lc[2], m_tk[2], m_ffv[2], m_ffts[2], m_ovf[2], m_ver[2];
  int mq[2][$];
  int cmax[2] = '{65535, 15};
  int sof[2]  = '{1, 0};

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_sc[k] = 0; m_fc[k] = 0; m_lc[k] = 0; m_tk[k] = 0;
      m_ffv[k] = 0; m_ffts[k] = 0; m_ovf[k] = 0; m_ver[k] = 0;
      mq[k].delete();
    end
  endtask

  task automatic m_step(input int k);
    int kind;
    bit pop;
    pop = (mq[k].size() > 0) && rdy;
    case (m_st[k])
      0: if (start) begin
        m_st[k] = 1; m_sc[k] = 0; m_fc[k] = 0; m_lc[k] = 0; m_tk[k] = 0;
        m_ffv[k] = 0; m_ffts[k] = 0; m_ovf[k] = 0;
        mq[k].delete();
        pop = 0;
      end
      1: begin
        kind = fail ? 2 : succ ? 1 : lazy ? 3 : 0;
        if (kind != 0) begin
          if (mq[k].size() - int'(pop) < 8) mq[k].push_back((kind << 16) | m_tk[k]);
          else m_ovf[k] = 1;
        end
        if (fail && m_ffv[k] == 0) begin m_ffv[k] = 1; m_ffts[k] = m_tk[k]; end
        if (succ) m_sc[k] = (m_sc[k] < cmax[k]) ? m_sc[k] + 1 : m_sc[k];
        if (fail) m_fc[k] = (m_fc[k] < cmax[k]) ? m_fc[k] + 1 : m_fc[k];
        if (lazy) m_lc[k] = (m_lc[k] < cmax[k]) ? m_lc[k] + 1 : m_lc[k];
        if (tick && m_tk[k] < 65535) m_tk[k]++;
        if (stop) m_st[k] = 3;
        else if (fail && sof[k] == 1) m_st[k] = 2;
      end
      2: if (stop) m_st[k] = 3;
      default: if (clear) m_st[k] = 0;
    endcase
    if (m_st[k] == 3 && (stop && start == start)) ;
    if (stop && m_st[k] == 3 && clear == clear) m_ver[k] = (m_fc[k] == 0 && m_sc[k] >= 1) ? 1 : 2;
    if (pop) void'(mq[k].pop_front());
  endtask

  task automatic chk_dut(input int k, input int sc, input int fc, input int lc, input int ffv,
                         input int ffts, input int ev, input int ek, input int ets,
                         input int ovf, input int st, input int ver);
    int hd;
    hd = (mq[k].size() > 0) ? mq[k][0] : 0;
    chk($sformatf("u%0d_state", k), st, m_st[k]);
    chk($sformatf("u%0d_succ_cnt", k), sc, m_sc[k]);
    chk($sformatf("u%0d_fail_cnt", k), fc, m_fc[k]);
    chk($sformatf("u%0d_lazy_cnt", k), lc, m_lc[k]);
    chk($sformatf("u%0d_ff_vld", k), ffv, m_ffv[k]);
    chk($sformatf("u%0d_ff_ts", k), ffts, m_ffts[k]);
    chk($sformatf("u%0d_evt_valid", k), ev, int'(mq[k].size() > 0));
    chk($sformatf("u%0d_evt_kind", k), ek, hd >> 16);
    chk($sformatf("u%0d_evt_ts", k), ets, hd & 16'hffff);
    chk($sformatf("u%0d_evt_ovf", k), ovf, m_ovf[k]);
    chk($sformatf("u%0d_verdict", k), ver, (m_st[k] == 3) ? m_ver[k] : 0);
  endtask

  task automatic check_all();
    chk_dut(0, int'(if0.succ_cnt), int'(if0.fail_cnt), int'(if0.lazy_cnt), int'(if0.first_fail_vld),
            int'(if0.first_fail_ts), int'(if0.evt_valid), int'(if0.evt_kind), int'(if0.evt_ts),
            int'(if0.evt_ovf), int'(if0.state), int'(if0.verdict));
    chk_dut(1, int'(if1.succ_cnt), int'(if1.fail_cnt), int'(if1.lazy_cnt), int'(if1.first_fail_vld),
            int'(if1.first_fail_ts), int'(if1.evt_valid), int'(if1.evt_kind), int'(if1.evt_ts),
            int'(if1.evt_ovf), int'(if1.state), int'(if1.verdict));
  endtask

  // Inputs are set at the falling edge, applied to model at the rising edge.
  task automatic cyc(input bit s, input bit p, input bit c, input bit t,
                     input bit sc, input bit fl, input bit lz, input bit r);
    {start, stop, clear, tick, succ, fail, lazy, rdy} = {s, p, c, t, sc, fl, lz, r};
    @(posedge sys_clk);
    m_step(0);
    m_step(1);
    @(negedge sys_clk);
    check_all();
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    #1;
    m_reset();
    check_all();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    @(negedge sys_clk);
    do_reset();
    // Basic pass: succ stamped at tick 2
    cyc(1,0,0,0, 0,0,0,0);
    cyc(0,0,0,1, 0,0,0,0);
    cyc(0,0,0,1, 0,0,0,0);
    cyc(0,0,0,1, 1,0,0,0);
    cyc(1,1,0,0, 0,0,0,0);
    chk("basic_state", if0.state, 3);
    chk("basic_verdict", if0.verdict, 1);
    chk("basic_kind", if0.evt_kind, 1);
    chk("basic_ts", if0.evt_ts, 2);
    cyc(0,0,0,0, 0,0,0,1);
    // First fail at ts=3
    cyc(0,0,1,0, 0,0,0,0);
    cyc(1,0,0,0, 0,0,0,0);
    for (int i = 0; i < 3; i++) cyc(0,0,0,1, 0,0,0,0);
    cyc(0,0,0,1, 0,1,0,0);
    chk("ff_state", if0.state, 2);
    chk("ff_ts", if0.first_fail_ts, 3);
    cyc(0,0,0,1, 1,0,0,0);
    chk("ff_succ_frozen", if0.succ_cnt, 0);
    cyc(0,1,0,0, 0,0,0,0);
    chk("ff_verdict", if0.verdict, 2);
    // Simultaneous results
    cyc(0,0,1,0, 0,0,0,1);
    cyc(1,0,0,0, 0,0,0,0);
    cyc(0,0,0,0, 1,1,1,0);
    chk("sim_kind", if1.evt_kind, 2);
    chk("sim_lazy", if1.lazy_cnt, 1);
    cyc(0,0,0,0, 0,0,0,0);
    // Overflow, then push with pop while full
    cyc(0,1,0,0, 0,0,0,0);
    cyc(0,0,1,0, 0,0,0,0);
    cyc(1,0,0,0, 0,0,0,0);
    for (int i = 0; i < 9; i++) cyc(0,0,0,1, 1,0,0,0);
    chk("ovf_flag", if0.evt_ovf, 1);
    chk("ovf_succ", if0.succ_cnt, 9);
    cyc(0,0,0,1, 1,0,0,1);
    cyc(1,0,0,0, 0,0,0,0);
    // Saturation on the 4-bit instance
    for (int i = 0; i < 20; i++) cyc(0,0,0,0, 1,0,0,(i % 3) == 0);
    chk("sat_succ", if1.succ_cnt, 15);
    cyc(0,1,0,0, 0,0,0,0);
    for (int i = 0; i < 10; i++) cyc(0,0,0,0, 0,0,0,1);
    cyc(0,0,1,0, 0,0,0,0);
    chk("clear_idle", if0.state, 0);
    // Mid-run reset
    cyc(1,0,0,1, 1,0,1,0);
    cyc(0,0,0,1, 1,0,0,0);
    do_reset();
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else cyc($urandom_range(0,15) == 0, $urandom_range(0,24) == 0, $urandom_range(0,7) == 0,
               $urandom_range(0,1) == 1, $urandom_range(0,2) == 0, $urandom_range(0,15) == 0,
               $urandom_range(0,3) == 0, $urandom_range(0,2) != 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
